// File: rtl/alu_core.sv
// alu_core: registered ALU with split-operand capture, wait timeout and a two-cycle multiply.
//
// Ports:
//   clk        clock, all state on rising edge
//   RST        asynchronous active-low reset
//   CE         clock enable; low freezes FSM, counter and outputs
//   INP_VALID  operand valid: 00 none, 01 OPA, 10 OPB, 11 both
//   MODE       1 arithmetic, 0 logical
//   CMD        operation code
//   OPA, OPB   operands
//   CIN        carry-in for ADD_CIN / SUB_CIN
//   RES        registered result, WIDTH+2 bits
//   COUT       carry out of bit WIDTH-1 (ADD / ADD_CIN)
//   OFLOW      borrow (SUB*) or wrap (INC/DEC)
//   G, L, E    compare flags (CMP)
//   ERR        illegal command, missing-operand timeout or bad rotate amount
module alu_core #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CMD_WIDTH   = 3,
    parameter int unsigned WAIT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [1:0]           INP_VALID,
    input  logic                 MODE,
    input  logic [CMD_WIDTH:0]   CMD,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic [WIDTH+1:0]     RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 G,
    output logic                 L,
    output logic                 E,
    output logic                 ERR
);

    localparam int unsigned RW   = WIDTH + 2;
    localparam int unsigned ShW  = $clog2(WIDTH);
    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned OutW = RW + 6;

    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);
    localparam logic [OutW-1:0] ErrOut  = {{RW{1'b0}}, 6'b000001};

    typedef enum logic [1:0] {StIdle, StWait, StExec, StMul2} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 mode_q, cin_q, have_a_q;
    logic [CMD_WIDTH:0]   cmd_q;
    logic [CntW-1:0]      cnt_q;
    // {RES, COUT, OFLOW, G, L, E, ERR}
    logic [OutW-1:0]      out_q;

    logic                 alu_mode, alu_cin;
    logic [CMD_WIDTH:0]   alu_cmd;
    logic [WIDTH-1:0]     alu_a, alu_b;
    logic                 cmd_ok, need_a, need_b, is_mul;
    logic [RW-1:0]        alu_res, a_ext, b_ext;
    logic                 alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
    logic [WIDTH:0]       sum_plain, sum_cin, cin_w;
    logic [2*WIDTH-1:0]   rot_l, rot_r;
    logic [OutW-1:0]      alu_out;

    // Operand source: live inputs in IDLE, latched operand plus the arriving one in WAIT,
    // fully latched operands in EXEC (multiply second stage).
    always_comb begin
        alu_mode = mode_q;
        alu_cmd  = cmd_q;
        alu_cin  = cin_q;
        alu_a    = a_q;
        alu_b    = b_q;
        if (state_q == StIdle) begin
            alu_mode = MODE;
            alu_cmd  = CMD;
            alu_cin  = CIN;
            alu_a    = OPA;
            alu_b    = OPB;
        end else if (state_q == StWait) begin
            alu_a = have_a_q ? a_q : OPA;
            alu_b = have_a_q ? OPB : b_q;
        end
    end

    always_comb begin
        need_a = 1'b1;
        need_b = 1'b1;
        is_mul = 1'b0;
        if (alu_mode) begin
            cmd_ok = (alu_cmd <= (CMD_WIDTH + 1)'(10));
            case (alu_cmd)
                4'd4, 4'd5:  need_b = 1'b0;
                4'd6, 4'd7:  need_a = 1'b0;
                4'd9, 4'd10: is_mul = 1'b1;
                default:     ;
            endcase
        end else begin
            cmd_ok = (alu_cmd <= (CMD_WIDTH + 1)'(13));
            case (alu_cmd)
                4'd6, 4'd8, 4'd9:   need_b = 1'b0;
                4'd7, 4'd10, 4'd11: need_a = 1'b0;
                default:            ;
            endcase
        end
    end

    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_l     = 1'b0;
        alu_e     = 1'b0;
        alu_err   = 1'b0;
        a_ext     = {2'b00, alu_a};
        b_ext     = {2'b00, alu_b};
        cin_w     = {{WIDTH{1'b0}}, alu_cin};
        sum_plain = {1'b0, alu_a} + {1'b0, alu_b};
        sum_cin   = sum_plain + cin_w;
        rot_l     = {alu_a, alu_a} << alu_b[ShW-1:0];
        rot_r     = {alu_a, alu_a} >> alu_b[ShW-1:0];
        if (!cmd_ok) begin
            alu_err = 1'b1;
        end else if (alu_mode) begin
            case (alu_cmd)
                4'd0: begin
                    alu_res  = {1'b0, sum_plain};
                    alu_cout = sum_plain[WIDTH];
                end
                4'd1: begin
                    alu_res   = a_ext - b_ext;
                    alu_oflow = (alu_a < alu_b);
                end
                4'd2: begin
                    alu_res  = {1'b0, sum_cin};
                    alu_cout = sum_cin[WIDTH];
                end
                4'd3: begin
                    alu_res   = a_ext - b_ext - {{(RW-1){1'b0}}, alu_cin};
                    alu_oflow = ({1'b0, alu_a} < ({1'b0, alu_b} + cin_w));
                end
                4'd4: begin
                    alu_res   = {2'b00, alu_a + WIDTH'(1)};
                    alu_oflow = &alu_a;
                end
                4'd5: begin
                    alu_res   = {2'b00, alu_a - WIDTH'(1)};
                    alu_oflow = ~|alu_a;
                end
                4'd6: begin
                    alu_res   = {2'b00, alu_b + WIDTH'(1)};
                    alu_oflow = &alu_b;
                end
                4'd7: begin
                    alu_res   = {2'b00, alu_b - WIDTH'(1)};
                    alu_oflow = ~|alu_b;
                end
                4'd8: begin
                    alu_g = (alu_a > alu_b);
                    alu_l = (alu_a < alu_b);
                    alu_e = (alu_a == alu_b);
                end
                4'd9:    alu_res = (a_ext + RW'(1)) * (b_ext + RW'(1));
                4'd10:   alu_res = (a_ext << 1) * b_ext;
                default: alu_err = 1'b1;
            endcase
        end else begin
            case (alu_cmd)
                4'd0:  alu_res = {2'b00, alu_a & alu_b};
                4'd1:  alu_res = {2'b00, ~(alu_a & alu_b)};
                4'd2:  alu_res = {2'b00, alu_a | alu_b};
                4'd3:  alu_res = {2'b00, ~(alu_a | alu_b)};
                4'd4:  alu_res = {2'b00, alu_a ^ alu_b};
                4'd5:  alu_res = {2'b00, ~(alu_a ^ alu_b)};
                4'd6:  alu_res = {2'b00, ~alu_a};
                4'd7:  alu_res = {2'b00, ~alu_b};
                4'd8:  alu_res = {2'b00, alu_a >> 1};
                4'd9:  alu_res = {2'b00, alu_a << 1};
                4'd10: alu_res = {2'b00, alu_b >> 1};
                4'd11: alu_res = {2'b00, alu_b << 1};
                4'd12: begin
                    alu_res = {2'b00, rot_l[2*WIDTH-1:WIDTH]};
                    alu_err = |alu_b[WIDTH-1:ShW];
                end
                4'd13: begin
                    alu_res = {2'b00, rot_r[WIDTH-1:0]};
                    alu_err = |alu_b[WIDTH-1:ShW];
                end
                default: alu_err = 1'b1;
            endcase
        end
        alu_out = {alu_res, alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err};
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            cmd_q    <= '0;
            cin_q    <= 1'b0;
            have_a_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else if (CE) begin
            unique case (state_q)
                StIdle: begin
                    if (INP_VALID != 2'b00) begin
                        mode_q <= MODE;
                        cmd_q  <= CMD;
                        cin_q  <= CIN;
                        if (!cmd_ok) begin
                            out_q   <= ErrOut;
                            state_q <= StExec;
                        end else if (need_a && need_b) begin
                            if (INP_VALID == 2'b11) begin
                                a_q <= OPA;
                                b_q <= OPB;
                                // Multiplies produce their result in EXEC from latched operands.
                                if (!is_mul) out_q <= alu_out;
                                state_q <= StExec;
                            end else begin
                                have_a_q <= INP_VALID[0];
                                if (INP_VALID[0]) a_q <= OPA;
                                else              b_q <= OPB;
                                cnt_q   <= '0;
                                state_q <= StWait;
                            end
                        end else begin
                            out_q <= ((need_a && INP_VALID[0]) || (need_b && INP_VALID[1])) ?
                                     alu_out : ErrOut;
                            state_q <= StExec;
                        end
                    end
                end
                StWait: begin
                    if (have_a_q ? INP_VALID[1] : INP_VALID[0]) begin
                        if (have_a_q) b_q <= OPB;
                        else          a_q <= OPA;
                        if (!is_mul) out_q <= alu_out;
                        state_q <= StExec;
                    end else if (cnt_q == CntLast) begin
                        out_q   <= ErrOut;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StExec: begin
                    if (is_mul) begin
                        out_q   <= alu_out;
                        state_q <= StMul2;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMul2:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign {RES, COUT, OFLOW, G, L, E, ERR} = out_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector scoreboard bench for alu_core. The driver pushes the
// hand-computed response with the cycle it is due; a monitor pops and compares.
module tb_alu_core;

    logic        clk;
    logic        RST;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic        MODE;
    logic [3:0]  CMD;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic        CIN;
    logic [9:0]  RES;
    logic        COUT, OFLOW, G, L, E, ERR;
    logic [15:0] dut_out;

    alu_core #(
        .WIDTH       (8),
        .CMD_WIDTH   (3),
        .WAIT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .CE        (CE),
        .INP_VALID (INP_VALID),
        .MODE      (MODE),
        .CMD       (CMD),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    // {RES, COUT, OFLOW, G, L, E, ERR}
    assign dut_out = {RES, COUT, OFLOW, G, L, E, ERR};

    typedef struct packed {
        int          due;
        logic [15:0] v;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] last_exp;
    exp_t        mon_e;
    string       mon_n;

    localparam logic [15:0] ErrVec = {10'h000, 6'b000001};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got RES=%h flags(cout,ofl,g,l,e,err)=%b, expected RES=%h flags=%b",
                     name, act[15:6], act[5:0], exp[15:6], exp[5:0]);
        end
    endtask

    task automatic push(input string name, input int due, input logic [15:0] v);
        exp_t e;
        e.due = due;
        e.v   = v;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            INP_VALID = 2'b00;
        end
    endtask

    task automatic run_vec(input string name, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv,
                           input logic cin, input bit mul, input logic [15:0] exp);
        int c;
        @(negedge clk);
        MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin; INP_VALID = iv;
        c = cyc;
        if (mul) begin
            push({name, "_hold"}, c + 1, last_exp);
            push(name, c + 2, exp);
        end else begin
            push(name, c + 1, exp);
        end
        last_exp = exp;
        idle(3);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (mon_e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: sample due at cycle %0d missed, now %0d", mon_n, mon_e.due, cyc);
            end else begin
                check(mon_n, dut_out, mon_e.v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        RST = 1'b1; CE = 1'b1; INP_VALID = 2'b00; MODE = 1'b0; CMD = 4'd0;
        OPA = 8'h00; OPB = 8'h00; CIN = 1'b0;
        #1 RST = 1'b0;
        #2 check("reset_async", dut_out, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset_hold", dut_out, 16'h0000);
        RST = 1'b1;
        last_exp = 16'h0000;

        // Arithmetic
        run_vec("add_carry",   1'b1, 4'd0,  8'hFF, 8'h01, 2'b11, 1'b1, 0, {10'h100, 6'b100000});
        run_vec("sub_borrow",  1'b1, 4'd1,  8'h05, 8'h07, 2'b11, 1'b1, 0, {10'h3FE, 6'b010000});
        run_vec("sub_pos",     1'b1, 4'd1,  8'h07, 8'h05, 2'b11, 1'b0, 0, {10'h002, 6'b000000});
        run_vec("add_cin",     1'b1, 4'd2,  8'h80, 8'h7F, 2'b11, 1'b1, 0, {10'h100, 6'b100000});
        run_vec("sub_cin",     1'b1, 4'd3,  8'h05, 8'h05, 2'b11, 1'b1, 0, {10'h3FF, 6'b010000});
        run_vec("inc_a_wrap",  1'b1, 4'd4,  8'hFF, 8'h00, 2'b01, 1'b0, 0, {10'h000, 6'b010000});
        run_vec("dec_a_wrap",  1'b1, 4'd5,  8'h00, 8'h33, 2'b01, 1'b0, 0, {10'h0FF, 6'b010000});
        run_vec("dec_b",       1'b1, 4'd7,  8'h44, 8'h10, 2'b10, 1'b0, 0, {10'h00F, 6'b000000});
        run_vec("inc_b",       1'b1, 4'd6,  8'h00, 8'h7F, 2'b11, 1'b0, 0, {10'h080, 6'b000000});
        run_vec("cmp_lt",      1'b1, 4'd8,  8'h03, 8'h09, 2'b11, 1'b0, 0, {10'h000, 6'b000100});
        run_vec("cmp_eq",      1'b1, 4'd8,  8'h09, 8'h09, 2'b11, 1'b0, 0, {10'h000, 6'b000010});
        run_vec("cmp_gt",      1'b1, 4'd8,  8'h0A, 8'h02, 2'b11, 1'b0, 0, {10'h000, 6'b001000});
        run_vec("mul_inc",     1'b1, 4'd9,  8'h03, 8'h04, 2'b11, 1'b0, 1, {10'h014, 6'b000000});
        run_vec("mul_shl",     1'b1, 4'd10, 8'hFF, 8'hFF, 2'b11, 1'b0, 1, {10'h002, 6'b000000});
        // Logical
        run_vec("and",         1'b0, 4'd0,  8'hF0, 8'h3C, 2'b11, 1'b0, 0, {10'h030, 6'b000000});
        run_vec("nand",        1'b0, 4'd1,  8'hF0, 8'h3C, 2'b11, 1'b0, 0, {10'h0CF, 6'b000000});
        run_vec("nor",         1'b0, 4'd3,  8'h0F, 8'h30, 2'b11, 1'b0, 0, {10'h0C0, 6'b000000});
        run_vec("xor",         1'b0, 4'd4,  8'hF0, 8'h3C, 2'b11, 1'b0, 0, {10'h0CC, 6'b000000});
        run_vec("shl1_a",      1'b0, 4'd9,  8'h81, 8'h00, 2'b01, 1'b0, 0, {10'h002, 6'b000000});
        run_vec("shr1_b",      1'b0, 4'd10, 8'h00, 8'h81, 2'b10, 1'b0, 0, {10'h040, 6'b000000});
        run_vec("rol_bad_amt", 1'b0, 4'd12, 8'h81, 8'h11, 2'b11, 1'b0, 0, {10'h003, 6'b000001});
        run_vec("ror",         1'b0, 4'd13, 8'h81, 8'h03, 2'b11, 1'b0, 0, {10'h030, 6'b000000});
        // Errors
        run_vec("bad_cmd_log", 1'b0, 4'd14, 8'h12, 8'h34, 2'b11, 1'b0, 0, ErrVec);
        run_vec("bad_cmd_ari", 1'b1, 4'd11, 8'h12, 8'h34, 2'b11, 1'b0, 0, ErrVec);
        run_vec("inc_a_no_a",  1'b1, 4'd4,  8'h12, 8'h34, 2'b10, 1'b0, 0, ErrVec);
        run_vec("add_small",   1'b1, 4'd0,  8'h10, 8'h20, 2'b11, 1'b0, 0, {10'h030, 6'b000000});

        // Split ADD: A first, B three cycles later with different live CMD/OPA.
        @(negedge clk);
        MODE = 1'b1; CMD = 4'd0; OPA = 8'h05; OPB = 8'hEE; INP_VALID = 2'b01;
        c = cyc;
        push("split_add_wait", c + 1, last_exp);
        idle(2);
        @(negedge clk);
        MODE = 1'b0; CMD = 4'd4; OPA = 8'hAA; OPB = 8'h07; INP_VALID = 2'b10;
        push("split_add", cyc + 1, {10'h00C, 6'b000000});
        last_exp = {10'h00C, 6'b000000};
        idle(3);

        // Split MUL_INC: B first, then A; result two cycles after A arrives.
        @(negedge clk);
        MODE = 1'b1; CMD = 4'd9; OPA = 8'h00; OPB = 8'h02; INP_VALID = 2'b10;
        c = cyc;
        push("split_mul_wait", c + 1, last_exp);
        @(negedge clk);
        MODE = 1'b0; CMD = 4'd0; OPA = 8'h05; OPB = 8'hFF; INP_VALID = 2'b01;
        push("split_mul_hold", c + 2, last_exp);
        push("split_mul", c + 3, {10'h012, 6'b000000});
        last_exp = {10'h012, 6'b000000};
        idle(4);

        // CE low: a full command is ignored.
        @(negedge clk);
        CE = 1'b0; MODE = 1'b1; CMD = 4'd0; OPA = 8'h01; OPB = 8'h01; INP_VALID = 2'b11;
        push("ce_hold", cyc + 1, last_exp);
        @(negedge clk);
        CE = 1'b1; INP_VALID = 2'b00;
        idle(2);

        // Timeout: 16 enabled cycles in WAIT, with 4 CE-low cycles not counted.
        @(negedge clk);
        MODE = 1'b1; CMD = 4'd0; OPA = 8'h09; OPB = 8'h00; INP_VALID = 2'b01; CE = 1'b1;
        c = cyc;
        push("timeout_wait", c + 1, last_exp);
        push("timeout_pre", c + 20, last_exp);
        push("timeout_err", c + 21, ErrVec);
        @(negedge clk); INP_VALID = 2'b00;
        @(negedge clk);
        @(negedge clk); CE = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); CE = 1'b1;
        while (cyc < c + 22) @(negedge clk);
        last_exp = ErrVec;
        run_vec("post_timeout", 1'b1, 4'd0, 8'h02, 8'h03, 2'b11, 1'b0, 0, {10'h005, 6'b000000});

        // Async reset while waiting for B.
        @(negedge clk);
        MODE = 1'b1; CMD = 4'd0; OPA = 8'h01; OPB = 8'h00; INP_VALID = 2'b01;
        @(negedge clk); INP_VALID = 2'b00;
        @(negedge clk);
        #2 RST = 1'b0;
        #1 check("reset_mid_wait", dut_out, 16'h0000);
        last_exp = 16'h0000;
        @(negedge clk); RST = 1'b1;
        run_vec("post_reset", 1'b1, 4'd0, 8'h04, 8'h04, 2'b11, 1'b0, 0, {10'h008, 6'b000000});

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected sample at cycle %0d never compared", mon_n, mon_e.due);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
